// File: rtl/serial_arb_pkg.sv
// Shared types and helpers for the serial transmitter arbiter.
package serial_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate so the search starts after `last`,
// find the first request, then map the offset back to a requester index.
module rr_priority_picker
  import serial_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] sel
);

  logic [N-1:0] rot;
  int           first;

  // Rotate, find-first (lowest offset wins), un-rotate.
  always_comb begin
    rot   = '0;
    first = 0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[IDX_W'((j + int'(last) + 1) % N)];
    end
    for (int j = N - 1; j >= 0; j--) begin
      first = rot[j] ? j : first;
    end
    any = |rot;
    sel = IDX_W'((first + int'(last) + 1) % N);
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-aware round-robin arbiter feeding one serial_transmitter; a grant is
// held until req_last is accepted or the owner stays idle for TIMEOUT_CYCLES.
module serial_tx_arbiter
  import serial_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]                tx_data,
  output logic                                 tx_data_available,
  input  logic                                 tx_ready,
  output logic                                 grant_valid,
  output logic [idx_width(NUM_REQUESTERS)-1:0] grant_index,
  output logic                                 timeout_pulse
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQUESTERS - 1);
  localparam logic             TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

  arb_state_t                    state_r, state_nxt;
  logic       [IDX_W-1:0]        grant_r, grant_nxt;
  logic       [IDX_W-1:0]        last_r, last_nxt;
  logic       [CNT_W-1:0]        cnt_r, cnt_nxt;
  logic                          pick_any;
  logic       [IDX_W-1:0]        pick_idx;
  logic                          sel_valid;
  logic                          sel_last;
  logic       [DATA_WIDTH-1:0]   sel_data;
  logic       [NUM_REQUESTERS-1:0] sel_onehot;
  logic                          xfer;

  rr_priority_picker #(
    .N     (NUM_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req  (req_valid),
    .last (last_r),
    .any  (pick_any),
    .sel  (pick_idx)
  );

  assign grant_index = grant_r;

  // Select the owning requester's lanes.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      sel_onehot[i] = (IDX_W'(i) == grant_r);
      sel_valid     = sel_onehot[i] ? req_valid[i] : sel_valid;
      sel_last      = sel_onehot[i] ? req_last[i] : sel_last;
      sel_data      = sel_onehot[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data;
    end
  end

  // Next-state and handshake outputs; outputs are quiet outside GRANTED.
  always_comb begin
    state_nxt         = state_r;
    grant_nxt         = grant_r;
    last_nxt          = last_r;
    cnt_nxt           = cnt_r;
    req_ready         = '0;
    tx_data           = '0;
    tx_data_available = 1'b0;
    grant_valid       = 1'b0;
    timeout_pulse     = 1'b0;
    xfer              = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = GRANTED;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANTED: begin
        grant_valid       = 1'b1;
        tx_data_available = sel_valid;
        tx_data           = sel_valid ? sel_data : '0;
        req_ready         = tx_ready ? sel_onehot : '0;
        xfer              = sel_valid & tx_ready;
        // A transfer beats a timeout that lands on the same cycle.
        if (xfer) begin
          if (sel_last) begin
            last_nxt  = grant_r;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = '0;
          end
        end else if (TIMEOUT_ON && (cnt_r == CNT_LIMIT)) begin
          timeout_pulse = 1'b1;
          last_nxt      = grant_r;
          state_nxt     = IDLE;
        end else if (!sel_valid) begin
          cnt_nxt = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= LAST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      grant_r <= grant_nxt;
      last_r  <= last_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Packet-aware round-robin arbiter sharing one `serial_transmitter` between `NUM_REQUESTERS` byte-stream producers (status reporter, debug dump, echo path, …). It sits between the requesters and the transmitter's `tx_data` / `tx_data_available` / `tx_ready` port. It holds a grant for a whole packet, delimited by `req_last`, so bytes from different sources never interleave on `serial_txd`. A stalled owner loses its grant after a configurable idle timeout.

## Interface
Parameters:
- `NUM_REQUESTERS`, default 4: number of producers, 2..16.
- `DATA_WIDTH`, default 8: byte width; must match the transmitter.
- `TIMEOUT_CYCLES`, default 65536: consecutive cycles without `req_valid` from the owner before its grant is revoked. 0 disables the timeout.

Ports:
- `clock`  in  1  single clock (the `int_osc` domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  requester i presents a byte.
- `req_data`  in  N*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  N  the presented byte is the final byte of its packet.
- `req_ready`  out  N  the byte from requester i is accepted this cycle.
- `tx_data`  out  DATA_WIDTH  to `serial_transmitter.tx_data`.
- `tx_data_available`  out  1  to `serial_transmitter.tx_data_available`.
- `tx_ready`  in  1  from `serial_transmitter.tx_ready`.
- `grant_valid`  out  1  a requester owns the transmitter.
- `grant_index`  out  IDX_W  owning requester; IDX_W = max(1, $clog2(N)).
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Transfer handshake:
  - The transmitter handshake is valid/ready: a byte moves when `tx_data_available && tx_ready` are both high.
  - The requester handshake is identical: a byte moves when `req_valid[i] && req_ready[i]`.
  - These two events always coincide.
- FSM state IDLE:
  - `grant_valid` = 0, `req_ready` = 0, `tx_data_available` = 0.
  - If any `req_valid` is high, select the first set bit searching from `last_grant+1` upward, wrapping modulo N.
  - Load `grant_index` with the selection, clear the idle counter, and go to GRANTED.
- FSM state GRANTED:
  - `tx_data` = `req_data[grant_index]` and `tx_data_available` = `req_valid[grant_index]`.
  - `req_ready[grant_index]` = `tx_ready`; all other `req_ready` bits are 0.
  - On a transfer with `req_last` = 1: set `last_grant` ← `grant_index` and go to IDLE.
  - On a transfer with `req_last` = 0: clear the idle counter and stay in GRANTED.
  - On a cycle with `req_valid[grant_index]` = 0: increment the idle counter. When it reaches `TIMEOUT_CYCLES` (and the timeout is nonzero), assert `timeout_pulse`, set `last_grant` ← `grant_index`, and go to IDLE.
  - The idle counter saturates and never wraps.
- Other requesters' `req_valid` is ignored while a grant is held. Requesters must hold `req_valid` and `req_data` stable until accepted.
- `tx_data` is don't-care when `tx_data_available` = 0; drive it to 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE.
  - `grant_valid` = 0, `grant_index` = 0, `timeout_pulse` = 0.
  - `last_grant` = N-1, so requester 0 wins the first arbitration.
  - `req_ready` = 0, `tx_data_available` = 0, `tx_data` = 0.
- Arbitration latency:
  - A request seen in IDLE at cycle t gives `grant_valid` = 1 at t+1.
  - The first byte can transfer at t+1 if `tx_ready` is high.
- A one-cycle IDLE bubble separates consecutive packets, including back-to-back packets from the same requester.
- A single-byte packet (`req_last` on the first byte) occupies exactly one GRANTED cycle when `tx_ready` = 1.
- Timeout:
  - `timeout_pulse` is high in the last GRANTED cycle.
  - `grant_valid` is 0 on the following cycle.
  - A transfer in the same cycle as the count reaching the limit takes priority: no timeout.
- Reset mid-packet abandons the packet immediately, with no further `req_ready`. The partial packet is the producer's problem.
- `tx_ready` low only stalls the transfer; it does not advance the idle counter while `req_valid` is high.

## Structure
- Package `serial_arb_pkg`:
  - Enum `arb_state_t` {IDLE, GRANTED}.
  - Function `idx_width(n)`.
- Sub-module `rr_priority_picker`:
  - Combinational.
  - Inputs: request vector, last index. Outputs: `any`, selected index.
  - Implemented by rotate, find-first, un-rotate.
- Top-level integration:
  - Instantiate between the producers and `serial_transmitter`.
  - Connect `tx_data_available`/`tx_ready` directly to the transmitter.

## Test plan
- After reset, requesters 0 and 2 both assert with 3-byte packets, `tx_ready` = 1 → `grant_index` = 0 for 3 bytes, one idle cycle, then `grant_index` = 2 for 3 bytes; output bytes are never interleaved.
- All 4 requesters continuously assert 1-byte packets → grants rotate 0,1,2,3,0,… with one transfer every 2 cycles.
- Owner 1 sends 2 bytes, then drops `req_valid`, with `TIMEOUT_CYCLES` = 16 → `timeout_pulse` 16 cycles after the drop; the next grant goes to requester 2 if it is pending, skipping 1.
- `tx_ready` is held low for 40 cycles mid-packet with `req_valid` high and `TIMEOUT_CYCLES` = 16 → no timeout, the byte is held stable on `tx_data`, and it transfers when `tx_ready` rises.
- `reset_n` is pulsed low mid-packet from requester 3 → `grant_valid`, `req_ready` and `tx_data_available` drop asynchronously; after release, requester 0 wins if it is requesting.
- A transfer coincides with the idle counter reaching the limit → no `timeout_pulse`, and the grant is retained.
